alu_serial: RTL
===============

// Module: alu_serial
// PURPOSE
//  Multi-cycle ALU: WIDTH-bit operation computed one 4-bit slice per clock.
//  Slices are ripple-chained (carry and shift bit) through registered state.
//  Sits beside the nibble-slice ALU path: wide operations at lower area, with start/busy/done handshake.
//  Result bus is tri-stated onto the shared data bus under n_oe.
// PARAMETERS
//  WIDTH   16  operand/result width; multiple of 4, 4..64
//  NSLICE  WIDTH/4  derived (localparam), slices per operation
// PORTS
//  clk           in   1      rising-edge clock
//  n_rst         in   1      asynchronous reset, active-low
//  start         in   1      request; sampled only when busy=0
//  a             in   WIDTH  operand A, latched on accepted start
//  b             in   WIDTH  operand B, latched on accepted start
//  op            in   4      operation code, latched on accepted start
//  invert        in   1      B bitwise inverted before op, latched
//  carry_in      in   1      carry/shift-in bit, active-high, latched
//  n_oe          in   1      0: drive result; 1: result = 'z (combinational, not latched)
//  result        out  WIDTH  last completed result (tri-state)
//  n_carry_out   out  1      carry out of last op, active-low
//  overflow_out  out  1      signed overflow of last ADD, else 0
//  busy          out  1      operation in progress
//  done          out  1      one-cycle pulse: result/flags just updated
// BEHAVIOUR
//  Reset: state IDLE; result reg 0; n_carry_out 1; overflow_out 0; busy 0; done 0; slice counter 0.
//  FSM IDLE -> RUN on start while IDLE; RUN -> IDLE after NSLICE slice edges.
//  Edge E0: start accepted, operands/op/invert/carry_in latched, busy=1.
//  Edges E1..EN (N=NSLICE): one slice each into internal work reg; output regs untouched.
//  Edge EN: result, n_carry_out, overflow_out load together; busy=0; done=1 for exactly one cycle.
//  start while busy ignored (not queued). start at the same edge that done rises is accepted (back-to-back).
//  Slice order: LSB->MSB for all ops except SHR (MSB->LSB); chain bit = carry or shifted-out bit.
//  Ops (bb = invert ? ~b : b):
//   0 ADD  a+bb+carry_in; overflow = signed overflow; SUB = ADD with invert=1, carry_in=1
//   1 AND  2 OR  3 XOR  (a with bb); carry out 0
//   4 SHL  {a[W-2:0],carry_in}; carry = a[W-1]
//   5 SHR  {carry_in,a[W-1:1]}; carry = a[0]
//   6 PASSB  bb; carry out 0
//   7-15 reserved: result 0, carry out 0
//  n_carry_out = ~carry; overflow_out = 0 for non-ADD ops.
//  Reset mid-operation: aborts immediately, all outputs to reset values, no done.
//  Counter wraps only via FSM return to IDLE; WIDTH=4 -> single slice, done at E1.
// CONFIGURATION
//  ALU_SERIAL_ZERO_EN defined: extra output zero_out (1 bit), =1 when last result==0,
//   updated at EN with other flags, reset value 1. Undefined: port absent, no logic.
// STRUCTURE
//  Package alu_pkg: op code constants (ALU_OP_ADD..ALU_OP_PASSB), SLICE_W=4.
//  Sub-module alu_slice4: combinational 4-bit slice (a4,b4,op,chain_in -> r4,chain_out,ovf);
//   top holds FSM, counter, work/output regs, tri-state.
// TESTING (WIDTH=16)
//  ADD a=7FFF b=0001 cin=0 -> done 4 cycles after E0, result 8000, n_carry_out 1, overflow_out 1.
//  SUB a=0000 b=0001 invert=1 cin=1 -> result FFFF, n_carry_out 1, overflow_out 0.
//  SHR a=8001 cin=1 -> C000, n_carry_out 0; SHL a=8001 cin=0 -> 0002, n_carry_out 0.
//  start pulsed at E2 of running op -> ignored, single done; start held through done -> back-to-back op.
//  n_rst low at E2 -> busy 0, result 0, no done; n_oe=1 -> result all z, flags still driven.
//  ALU_SERIAL_ZERO_EN: XOR a=1234 b=1234 -> result 0000, zero_out 1; op 9 -> result 0, n_carry_out 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU: slice width, operation codes and FSM state type.
package alu_pkg;

   localparam int unsigned SLICE_W = 4;

   // Operation codes; 7..15 are reserved and produce a zero result.
   localparam logic [3:0] ALU_OP_ADD   = 4'd0;
   localparam logic [3:0] ALU_OP_AND   = 4'd1;
   localparam logic [3:0] ALU_OP_OR    = 4'd2;
   localparam logic [3:0] ALU_OP_XOR   = 4'd3;
   localparam logic [3:0] ALU_OP_SHL   = 4'd4;
   localparam logic [3:0] ALU_OP_SHR   = 4'd5;
   localparam logic [3:0] ALU_OP_PASSB = 4'd6;

   typedef enum logic [0:0] {StIdle, StRun} alu_state_e;

endpackage

// File: rtl/alu_slice4.sv
// Combinational 4-bit ALU slice.
// Ports:
//   a4, b4    operand nibbles (b4 already conditionally inverted)
//   op        operation code
//   chain_in  carry in (ADD) or shift-in bit (SHL/SHR)
//   r4        result nibble
//   chain_out carry out (ADD) or shifted-out bit (SHL/SHR); 0 otherwise
//   ovf       signed overflow of this nibble's top bit (ADD only)
module alu_slice4
   import alu_pkg::*;
(
   input  logic [3:0] a4,
   input  logic [3:0] b4,
   input  logic [3:0] op,
   input  logic       chain_in,
   output logic [3:0] r4,
   output logic       chain_out,
   output logic       ovf
);

   logic [4:0] sum;

   always_comb begin
      sum       = {1'b0, a4} + {1'b0, b4} + {4'b0000, chain_in};
      r4        = 4'h0;
      chain_out = 1'b0;
      ovf       = 1'b0;
      case (op)
         ALU_OP_ADD: begin
            r4        = sum[3:0];
            chain_out = sum[4];
            // Only meaningful on the most significant slice.
            ovf       = (a4[3] == b4[3]) && (sum[3] != a4[3]);
         end
         ALU_OP_AND:   r4 = a4 & b4;
         ALU_OP_OR:    r4 = a4 | b4;
         ALU_OP_XOR:   r4 = a4 ^ b4;
         ALU_OP_SHL: begin
            r4        = {a4[2:0], chain_in};
            chain_out = a4[3];
         end
         ALU_OP_SHR: begin
            r4        = {chain_in, a4[3:1]};
            chain_out = a4[0];
         end
         ALU_OP_PASSB: r4 = b4;
         default: begin
            r4        = 4'h0;
            chain_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle ALU: a WIDTH-bit operation is computed one 4-bit slice per clock, with the
// carry / shift bit chained between slices through a register.
// Optional feature: define ALU_SERIAL_ZERO_EN to add the zero_out flag port.
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   start                request, accepted only while idle
//   a, b, op             operands and operation, latched on accepted start
//   invert, carry_in     invert B / carry-shift in, latched on accepted start
//   n_oe                 0: drive result, 1: result tri-stated
//   result               last completed result (tri-state)
//   n_carry_out          carry of last op, active-low
//   overflow_out         signed overflow of last ADD
//   busy, done           operation in progress / one-cycle completion pulse
//   zero_out             (ALU_SERIAL_ZERO_EN) last result was zero
module alu_serial
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             invert,
   input  logic             carry_in,
   input  logic             n_oe,
   output logic [WIDTH-1:0] result,
   output logic             n_carry_out,
   output logic             overflow_out,
   output logic             busy,
   output logic             done
`ifdef ALU_SERIAL_ZERO_EN
   ,
   output logic             zero_out
`endif
);

   localparam int unsigned NSLICE = WIDTH / SLICE_W;
   localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   alu_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [CntW-1:0]  slice_idx;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       op_q;
   logic             chain_q, chain_d;
   logic             n_carry_q, ovf_q, done_q;
   logic             accept, finish;
   logic [3:0]       s_a, s_b, s_r;
   logic             s_chain, s_ovf;

   // SHR walks MSB->LSB so the shifted bit ripples downward.
   assign slice_idx = (op_q == ALU_OP_SHR) ? (CntW'(NSLICE - 1) - cnt_q) : cnt_q;
   assign s_a       = a_q[SLICE_W*slice_idx +: SLICE_W];
   assign s_b       = b_q[SLICE_W*slice_idx +: SLICE_W];

   alu_slice4 u_slice (
      .a4        (s_a),
      .b4        (s_b),
      .op        (op_q),
      .chain_in  (chain_q),
      .r4        (s_r),
      .chain_out (s_chain),
      .ovf       (s_ovf)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      chain_d = chain_q;
      accept  = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               accept  = 1'b1;
               state_d = StRun;
               cnt_d   = '0;
               work_d  = '0;
               chain_d = carry_in;
            end
         end
         StRun: begin
            work_d[SLICE_W*slice_idx +: SLICE_W] = s_r;
            chain_d = s_chain;
            if (cnt_q == CntW'(NSLICE - 1)) begin
               finish  = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= ALU_OP_ADD;
         chain_q   <= 1'b0;
         work_q    <= '0;
         result_q  <= '0;
         n_carry_q <= 1'b1;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chain_q <= chain_d;
         work_q  <= work_d;
         done_q  <= finish;
         if (accept) begin
            a_q  <= a;
            b_q  <= invert ? ~b : b;
            op_q <= op;
         end
         if (finish) begin
            result_q  <= work_d;
            n_carry_q <= ~s_chain;
            // Final slice of an ADD is the MSB slice, so its overflow is the word overflow.
            ovf_q     <= (op_q == ALU_OP_ADD) && s_ovf;
         end
      end
   end

`ifdef ALU_SERIAL_ZERO_EN
   logic zero_q;
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         zero_q <= 1'b1;
      end else if (finish) begin
         zero_q <= (work_d == '0);
      end
   end
   assign zero_out = zero_q;
`endif

   assign result       = n_oe ? 'z : result_q;
   assign n_carry_out  = n_carry_q;
   assign overflow_out = ovf_q;
   assign busy         = (state_q == StRun);
   assign done         = done_q;

endmodule
